// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver: start-bit qualification, mid-bit data sampling,
// optional parity check and stop-bit check, with a one-cycle done strobe per frame.
module uart_rx_oversampled #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  // Tick counter must reach 15 per bit and SB_TICK-1 during the stop bit.
  localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = $clog2(DBIT);

  localparam logic [SW-1:0] MID_START = SW'(7);
  localparam logic [SW-1:0] BIT_END   = SW'(15);
  localparam logic [SW-1:0] STOP_END  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] LAST_BIT  = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sync;
  logic [SW-1:0]   r_s_cnt;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_shift;
  logic            r_par;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_frame_err;
  logic            r_parity_err;
  logic            r_busy;

  logic w_rx_s;
  logic w_par_err;

  assign w_rx_s    = r_sync[1];
  assign w_par_err = PARITY_EN && ((^r_shift ^ r_par) != PARITY_ODD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sync       <= 2'b11;
      r_s_cnt      <= '0;
      r_n          <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_dout       <= '0;
      r_done       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_s_cnt <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (s_tick) begin
            if (r_s_cnt == MID_START) begin
              // A line that is high again at mid start bit was only a glitch.
              if (!w_rx_s) begin
                r_state <= S_DATA;
                r_s_cnt <= '0;
                r_n     <= '0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
        end
        S_DATA: begin
          if (s_tick) begin
            if (r_s_cnt == BIT_END) begin
              r_shift <= {w_rx_s, r_shift[DBIT-1:1]};
              r_s_cnt <= '0;
              if (r_n == LAST_BIT) begin
                r_state <= PARITY_EN ? S_PARITY : S_STOP;
              end else begin
                r_n <= r_n + NW'(1);
              end
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
        end
        S_PARITY: begin
          if (s_tick) begin
            if (r_s_cnt == BIT_END) begin
              r_par   <= w_rx_s;
              r_s_cnt <= '0;
              r_state <= S_STOP;
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
        end
        S_STOP: begin
          if (s_tick) begin
            if (r_s_cnt == STOP_END) begin
              r_dout       <= r_shift;
              r_frame_err  <= ~w_rx_s;
              r_parity_err <= w_par_err;
              r_done       <= 1'b1;
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = r_dout;
  assign rx_done    = r_done;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign busy       = r_busy;

endmodule
